// File: rtl/lzrw1_pkg.sv
// ============================================================================
// lzrw1_pkg: LZRW1 group format types, constants and item-size helper.
// Rev 1.0
// ============================================================================
`default_nettype none

package lzrw1_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      CTRL_LO = 2'd1,
      CTRL_HI = 2'd2,
      DATA    = 2'd3
   } packer_state_t;

   localparam int LZRW1_GROUP_ITEMS = 16;
   localparam int LZRW1_CTRL_BYTES  = 2;

   function automatic logic [1:0] item_bytes(input logic is_copy);
      return is_copy ? 2'd2 : 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lzrw1_group_buffer.sv
// ============================================================================
// lzrw1_group_buffer: group byte store, 1-or-2-byte write, combinational read.
// Rev 1.0
// ============================================================================
`default_nettype none

module lzrw1_group_buffer #(
   parameter int BUF_BYTES = 32,
   parameter int ADDR_W    = $clog2(BUF_BYTES)
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic              wr_two,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [BUF_BYTES];

   // Copy words are stored high byte first so the stream carries them MSB first.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         if (wr_two) begin
            mem[wr_addr]                <= wr_data[15:8];
            mem[wr_addr + ADDR_W'(1)]   <= wr_data[7:0];
         end else begin
            mem[wr_addr]                <= wr_data[7:0];
         end
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/lzrw1_group_packer.sv
// ============================================================================
// lzrw1_group_packer: serialises LZRW1 items into ctrl-word + byte groups.
// Option: LZRW1_GROUP_STATS_EN adds group_count output.            Rev 1.0
// ============================================================================
`default_nettype none

module lzrw1_group_packer
   import lzrw1_pkg::*;
#(
   parameter int GROUP_ITEMS = LZRW1_GROUP_ITEMS,
   parameter int BUF_BYTES   = 2 * LZRW1_GROUP_ITEMS
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_copy,
   input  logic [15:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_byte,
   output logic        out_last,
   output logic        busy
`ifdef LZRW1_GROUP_STATS_EN
   ,
   output logic [15:0] group_count
`endif
);

   localparam int CNT_W  = $clog2(GROUP_ITEMS + 1);
   localparam int PTR_W  = $clog2(BUF_BYTES + 1);
   localparam int ADDR_W = $clog2(BUF_BYTES);

   packer_state_t            state, state_next;
   logic [CNT_W-1:0]         item_cnt;
   logic [PTR_W-1:0]         wr_ptr;
   logic [ADDR_W-1:0]        rd_ptr;
   logic [GROUP_ITEMS-1:0]   ctrl;
   logic                     last_grp;
   logic [7:0]               rd_data;
   logic                     accept;
   logic                     closing;
   logic                     last_data;
   logic                     data_done;

   assign accept    = in_valid && in_ready;
   assign closing   = accept && (in_last || (item_cnt == CNT_W'(GROUP_ITEMS - 1)));
   assign last_data = ({1'b0, rd_ptr} == (wr_ptr - PTR_W'(1)));
   assign data_done = (state == DATA) && out_ready && last_data;
   assign busy      = (state != COLLECT) || (item_cnt != '0);

   lzrw1_group_buffer #(
      .BUF_BYTES (BUF_BYTES),
      .ADDR_W    (ADDR_W)
   ) u_buf (
      .clock   (clock),
      .wr_en   (accept),
      .wr_two  (in_is_copy),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (in_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= COLLECT;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_byte   = 8'h00;
      out_last   = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            if (closing) state_next = CTRL_LO;
         end
         CTRL_LO: begin
            out_valid = 1'b1;
            out_byte  = ctrl[7:0];
            if (out_ready) state_next = CTRL_HI;
         end
         CTRL_HI: begin
            out_valid = 1'b1;
            out_byte  = ctrl[15:8];
            if (out_ready) state_next = DATA;
         end
         DATA: begin
            out_valid = 1'b1;
            out_byte  = rd_data;
            out_last  = last_grp && last_data;
            if (out_ready && last_data) state_next = COLLECT;
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         item_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ctrl     <= '0;
         last_grp <= 1'b0;
      end else if (accept) begin
         ctrl     <= ctrl | ({{(GROUP_ITEMS-1){1'b0}}, in_is_copy} << item_cnt);
         wr_ptr   <= wr_ptr + PTR_W'(item_bytes(in_is_copy));
         item_cnt <= item_cnt + CNT_W'(1);
         if (closing) last_grp <= in_last;
      end else if (data_done) begin
         item_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ctrl     <= '0;
         last_grp <= 1'b0;
      end else if ((state == DATA) && out_ready) begin
         rd_ptr   <= rd_ptr + ADDR_W'(1);
      end
   end

`ifdef LZRW1_GROUP_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)       group_count <= 16'h0000;
      else if (data_done) group_count <= group_count + 16'h0001;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lzrw1_group_packer.sv
// ============================================================================
// tb_lzrw1_group_packer: scoreboard bench with a group-level reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lzrw1_group_packer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_is_copy = 1'b0;
   logic [15:0] in_data = 16'h0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_byte;
   logic        out_last;
   logic        busy;
`ifdef LZRW1_GROUP_STATS_EN
   logic [15:0] group_count;
`endif

   lzrw1_group_packer dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_is_copy (in_is_copy),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_byte   (out_byte),
      .out_last   (out_last),
      .busy       (busy)
`ifdef LZRW1_GROUP_STATS_EN
      ,
      .group_count(group_count)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int seen   = 0;
   bit stall_en = 1'b0;

   // Expected stream entries: {last, byte}
   logic [8:0] exp_q [$];

   // Reference model: a group is a list of item byte sequences plus a ctrl word
   logic [15:0] m_ctrl = 16'h0;
   int          m_cnt  = 0;
   logic [7:0]  m_bytes [$];

   function automatic void model_reset();
      m_ctrl = 16'h0;
      m_cnt  = 0;
      m_bytes.delete();
   endfunction

   function automatic void model_push(input logic c, input logic [15:0] d, input logic l);
      m_ctrl[m_cnt] = c;
      if (c) begin
         m_bytes.push_back(d[15:8]);
         m_bytes.push_back(d[7:0]);
      end else begin
         m_bytes.push_back(d[7:0]);
      end
      m_cnt++;
      if (m_cnt == 16 || l) begin
         exp_q.push_back({1'b0, m_ctrl[7:0]});
         exp_q.push_back({1'b0, m_ctrl[15:8]});
         for (int i = 0; i < m_bytes.size(); i++)
            exp_q.push_back({(l && i == m_bytes.size() - 1), m_bytes[i]});
         model_reset();
      end
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Sink-side ready pattern
   always @(posedge clock) begin
      #1;
      out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // Monitor: compares every handshake, and checks hold/in_ready while presenting
   logic       held_valid = 1'b0;
   logic [8:0] held = 9'h0;
   always @(negedge clock) begin
      if (!reset_n) begin
         held_valid = 1'b0;
      end else if (out_valid) begin
         check("in_ready_during_emit", {15'h0, in_ready}, 16'h0);
         if (held_valid)
            check("stall_hold", {7'h0, out_last, out_byte}, {7'h0, held});
         if (out_ready) begin
            seen++;
            held_valid = 1'b0;
            if (exp_q.size() == 0) begin
               check("unexpected_byte", {7'h0, out_last, out_byte}, 16'hFFFF);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("stream_byte", {7'h0, out_last, out_byte}, {7'h0, e});
            end
         end else begin
            held_valid = 1'b1;
            held = {out_last, out_byte};
         end
      end else begin
         held_valid = 1'b0;
      end
   end

   task automatic send_item(input logic c, input logic [15:0] d, input logic l);
      bit acc = 1'b0;
      int n = 0;
      in_valid = 1'b1; in_is_copy = c; in_data = d; in_last = l;
      do begin
         @(negedge clock);
         acc = in_ready;
         @(posedge clock);
         n++;
      end while (!acc && n < 2000);
      if (!acc) check("send_timeout", 16'h0, 16'h1);
      else      model_push(c, d, l);
      #1;
      in_valid = 1'b0;
      in_is_copy = $urandom_range(0, 1);
      in_data = 16'($urandom);
      in_last = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(posedge clock);
         n++;
      end
      check({name, "_drain"}, 16'(exp_q.size()), 16'h0);
      @(posedge clock); #1;
      check({name, "_in_ready"}, {15'h0, in_ready}, 16'h1);
      check({name, "_busy"}, {15'h0, busy}, 16'h0);
      check({name, "_out_valid"}, {15'h0, out_valid}, 16'h0);
   endtask

   task automatic case3_items();
      send_item(1'b0, 16'h0061, 1'b0);
      send_item(1'b1, 16'h1234, 1'b0);
      send_item(1'b0, 16'h0062, 1'b1);
   endtask

   initial begin
      // Idle after reset
      repeat (3) @(posedge clock);
      @(negedge clock); reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("idle_in_ready", {15'h0, in_ready}, 16'h1);
         check("idle_out_valid", {15'h0, out_valid}, 16'h0);
         check("idle_busy", {15'h0, busy}, 16'h0);
         check("idle_out_byte", {8'h0, out_byte}, 16'h0);
      end
      @(posedge clock); #1;

      // 16 literals: full group of plain bytes
      for (int i = 0; i < 16; i++) send_item(1'b0, 16'(8'h41 + i), 1'b0);
      wait_drain("lit16");

      // 16 copies: worst-case buffer fill
      for (int i = 0; i < 16; i++) send_item(1'b1, 16'hA0B0 + 16'(i), 1'b0);
      wait_drain("copy16");

      // Short final group
      case3_items();
      wait_drain("short");

      // Same short group under random sink stalls
      stall_en = 1'b1;
      case3_items();
      wait_drain("short_stall");

      // 15 items then in_last on the 16th: exactly one group
      for (int i = 0; i < 16; i++) send_item(i[0], 16'($urandom), i == 15);
      wait_drain("last_at_full");

      // Random item mix with gaps and stalls
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
         #1;
         send_item(1'(($urandom_range(0, 1))), 16'($urandom), ($urandom_range(0, 19) == 0) || i == 299);
      end
      wait_drain("random");

      // Reset during DATA, then a fresh one-literal group
      stall_en = 1'b0;
      begin
         int base;
         int n = 0;
         base = seen;
         for (int i = 0; i < 16; i++) send_item(1'b1, 16'($urandom), 1'b0);
         while (seen < base + 7 && n < 2000) begin
            @(posedge clock);
            n++;
         end
         check("reset_reach_data", {15'h0, (seen >= base + 7)}, 16'h1);
         @(posedge clock); #2;
         reset_n = 1'b0;
         #1;
         check("rst_out_valid", {15'h0, out_valid}, 16'h0);
         check("rst_in_ready", {15'h0, in_ready}, 16'h1);
         check("rst_busy", {15'h0, busy}, 16'h0);
         check("rst_out_byte", {8'h0, out_byte}, 16'h0);
         exp_q.delete();
         model_reset();
         repeat (2) @(negedge clock);
         reset_n = 1'b1;
         @(posedge clock); #1;
         send_item(1'b0, 16'h00C3, 1'b1);
         wait_drain("after_reset");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
